// File: rtl/tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_pkg
// Description : Shared widths, state encodings and helpers for the TX code
//               sequencer (same 16x256 code table layout as the RX side).
// Revision    : 1.0 - initial release
// ============================================================================
package tx_pkg;

    localparam int CODE_W        = 4;
    localparam int ADDR_W        = 8;
    localparam int ROM_W         = 16;
    localparam int CHIPS_DEFAULT = 255;

    localparam int                c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_PRIME = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_RUN   = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 2'd3;

    // DAC sample for a chip: +amp for 1, -amp for 0, silent when not emitting.
    function automatic logic signed [ROM_W-1:0] bipolar(
        input logic                    valid,
        input logic                    chip,
        input logic signed [ROM_W-1:0] amp
    );
        if (!valid) begin
            return '0;
        end
        return chip ? amp : -amp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_chip_timer.sv
`default_nettype none
// ============================================================================
// Module      : tx_chip_timer
// Description : Free-running 0..DIV-1 chip-period counter with first/last
//               cycle strobes; held at zero while cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_chip_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_first_cycle,
    output logic o_last_cycle
);

    localparam logic [7:0] c_LAST = 8'(DIV - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (i_clear || (r_cnt == c_LAST)) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_first_cycle = (r_cnt == 8'd0);
    assign o_last_cycle  = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/tx_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_code_sequencer
// Description : Reads rows 0..CHIPS-1 of the external code BRAM, extracts the
//               selected code column and streams it as DIV-clock chips plus a
//               bipolar DAC sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_code_sequencer
    import tx_pkg::*;
#(
    parameter int                        CHIPS = CHIPS_DEFAULT,
    parameter int                        DIV   = 4,
    parameter logic signed [ROM_W-1:0]   AMP   = 16'sd8191
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CODE_W-1:0]        code_sel,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [ROM_W-1:0]         rom_data,
    output logic                     busy,
    output logic                     chip_valid,
    output logic                     chip,
    output logic [ADDR_W-1:0]        chip_idx,
    output logic signed [ROM_W-1:0]  tx_sample,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(CHIPS - 1);

    logic [c_ST_W-1:0]        r_state,      w_state_nxt;
    logic [CODE_W-1:0]        r_code,       w_code_nxt;
    logic                     r_busy,       w_busy_nxt;
    logic                     r_chip_valid, w_chip_valid_nxt;
    logic                     r_chip,       w_chip_nxt;
    logic [ADDR_W-1:0]        r_chip_idx,   w_chip_idx_nxt;
    logic signed [ROM_W-1:0]  r_tx_sample,  w_tx_sample_nxt;
    logic                     r_done,       w_done_nxt;
    logic                     r_prime_wait, w_prime_wait_nxt;
    logic                     r_rd_pend;
    logic                     r_hold;

    logic w_first;
    logic w_last;
    logic w_timer_clear;
    logic w_rom_bit;
    logic w_next_bit;
    logic w_fetch;
    logic w_prime_fetch;

    assign w_timer_clear = (r_state != c_ST_RUN) || abort;

    tx_chip_timer #(
        .DIV (DIV)
    ) u_chip_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_timer_clear),
        .o_first_cycle (w_first),
        .o_last_cycle  (w_last)
    );

    // Code 0 is the MSB column of each row.
    assign w_rom_bit     = rom_data[4'(ROM_W - 1) - r_code];
    // With DIV=2 the prefetched row arrives in the chip's last cycle, so bypass the hold register.
    assign w_next_bit    = r_rd_pend ? w_rom_bit : r_hold;
    assign w_prime_fetch = (r_state == c_ST_PRIME) && !r_prime_wait;
    assign w_fetch       = (r_state == c_ST_RUN) && w_first && (r_chip_idx < c_LAST_IDX);

    assign rom_en   = w_prime_fetch | w_fetch;
    assign rom_addr = w_fetch ? (r_chip_idx + 8'd1) : '0;

    always_comb begin
        w_state_nxt      = r_state;
        w_code_nxt       = r_code;
        w_busy_nxt       = r_busy;
        w_chip_valid_nxt = r_chip_valid;
        w_chip_nxt       = r_chip;
        w_chip_idx_nxt   = r_chip_idx;
        w_done_nxt       = 1'b0;
        w_prime_wait_nxt = r_prime_wait;

        if ((r_state != c_ST_IDLE) && abort) begin
            w_state_nxt      = c_ST_IDLE;
            w_busy_nxt       = 1'b0;
            w_chip_valid_nxt = 1'b0;
            w_chip_nxt       = 1'b0;
            w_chip_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start && !abort) begin
                        w_state_nxt      = c_ST_PRIME;
                        w_code_nxt       = code_sel;
                        w_busy_nxt       = 1'b1;
                        w_prime_wait_nxt = 1'b0;
                    end
                end
                c_ST_PRIME: begin
                    if (!r_prime_wait) begin
                        w_prime_wait_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = c_ST_RUN;
                        w_chip_nxt       = w_rom_bit;
                        w_chip_idx_nxt   = '0;
                        w_chip_valid_nxt = 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_last) begin
                        if (r_chip_idx == c_LAST_IDX) begin
                            w_state_nxt      = c_ST_DONE;
                            w_chip_valid_nxt = 1'b0;
                            w_chip_nxt       = 1'b0;
                            w_done_nxt       = 1'b1;
                        end else begin
                            w_chip_nxt     = w_next_bit;
                            w_chip_idx_nxt = r_chip_idx + 8'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    w_state_nxt = c_ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt      = c_ST_IDLE;
                    w_busy_nxt       = 1'b0;
                    w_chip_valid_nxt = 1'b0;
                end
            endcase
        end

        w_tx_sample_nxt = bipolar(w_chip_valid_nxt, w_chip_nxt, AMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_code       <= '0;
            r_busy       <= 1'b0;
            r_chip_valid <= 1'b0;
            r_chip       <= 1'b0;
            r_chip_idx   <= '0;
            r_tx_sample  <= '0;
            r_done       <= 1'b0;
            r_prime_wait <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_hold       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_code       <= w_code_nxt;
            r_busy       <= w_busy_nxt;
            r_chip_valid <= w_chip_valid_nxt;
            r_chip       <= w_chip_nxt;
            r_chip_idx   <= w_chip_idx_nxt;
            r_tx_sample  <= w_tx_sample_nxt;
            r_done       <= w_done_nxt;
            r_prime_wait <= w_prime_wait_nxt;
            r_rd_pend    <= w_fetch;
            r_hold       <= w_next_bit;
        end
    end

    assign busy       = r_busy;
    assign chip_valid = r_chip_valid;
    assign chip       = r_chip;
    assign chip_idx   = r_chip_idx;
    assign tx_sample  = r_tx_sample;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_code_sequencer
// Description : Directed self-checking bench for tx_code_sequencer (DIV=4 and
//               DIV=2 instances, each with its own BRAM model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_code_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start4 = 1'b0, abort4 = 1'b0;
    logic [3:0] code4 = '0;
    logic rom_en4, busy4, valid4, chip4, done4;
    logic [7:0] rom_addr4, idx4;
    logic [15:0] rom_data4 = '0;
    logic signed [15:0] samp4;

    logic start2 = 1'b0, abort2 = 1'b0;
    logic [3:0] code2 = '0;
    logic rom_en2, busy2, valid2, chip2, done2;
    logic [7:0] rom_addr2, idx2;
    logic [15:0] rom_data2 = '0;
    logic signed [15:0] samp2;

    int errors = 0;
    int checks = 0;

    tx_code_sequencer #(.CHIPS(255), .DIV(4), .AMP(16'sd8191)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .code_sel(code4),
        .rom_en(rom_en4), .rom_addr(rom_addr4), .rom_data(rom_data4), .busy(busy4),
        .chip_valid(valid4), .chip(chip4), .chip_idx(idx4), .tx_sample(samp4), .done(done4)
    );

    tx_code_sequencer #(.CHIPS(255), .DIV(2), .AMP(16'sd8191)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .code_sel(code2),
        .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2), .busy(busy2),
        .chip_valid(valid2), .chip(chip2), .chip_idx(idx2), .tx_sample(samp2), .done(done2)
    );

    function automatic logic [15:0] rom_row(input logic [7:0] a);
        logic [15:0] v;
        case (a)
            8'd0:    v = 16'b0110_1001_0011_1100;
            8'd1:    v = 16'b1000_0110_1100_1010;
            default: v = {a, ~a} ^ {a[2:0], a, a[7:3]} ^ 16'h5A3C;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (rom_en4) rom_data4 <= rom_row(rom_addr4);
        if (rom_en2) rom_data2 <= rom_row(rom_addr2);
    end

    task automatic do_start(input bit use2, input logic [3:0] c);
        @(negedge clk);
        if (use2) begin start2 = 1'b1; code2 = c; end
        else begin start4 = 1'b1; code4 = c; end
        @(posedge clk);
    endtask

    // Watches one full sequence after its start edge; n counts edges since start.
    task automatic observe(input bit use2, input int c, input int div, input int start_at,
                           output int s_err, output int v_cnt, output int d_at, output int d_cnt,
                           output int rd_cnt, output int a_err, output bit over,
                           output logic c0, output logic c1,
                           output logic signed [15:0] sm0, output logic signed [15:0] sm1);
        int last_n, k;
        logic v, ch, bz, dn, en, expv, expc;
        logic [7:0] ix, ad;
        logic signed [15:0] sm, exps;
        logic [15:0] row;
        s_err = 0; v_cnt = 0; d_at = -1; d_cnt = 0; rd_cnt = 0; a_err = 0; over = 1'b0;
        c0 = 1'b0; c1 = 1'b0; sm0 = '0; sm1 = '0;
        last_n = 2 + 255 * div;
        for (int n = 0; n <= last_n + 6; n++) begin
            @(negedge clk);
            if (use2) begin
                start2 = (n == start_at);
                if (n == start_at) code2 = 4'hF;
            end else begin
                start4 = (n == start_at);
                if (n == start_at) code4 = 4'hF;
            end
            v  = use2 ? valid2 : valid4;
            ch = use2 ? chip2 : chip4;
            bz = use2 ? busy2 : busy4;
            dn = use2 ? done2 : done4;
            en = use2 ? rom_en2 : rom_en4;
            ix = use2 ? idx2 : idx4;
            ad = use2 ? rom_addr2 : rom_addr4;
            sm = use2 ? samp2 : samp4;
            expv = (n >= 2) && (n <= last_n - 1);
            if (v === 1'b1) v_cnt++;
            if (v !== expv) s_err++;
            if (bz !== (n <= last_n)) s_err++;
            if (expv) begin
                k = (n - 2) / div;
                row = rom_row(8'(k));
                expc = row[15 - c];
                exps = expc ? 16'sd8191 : -16'sd8191;
                if (ch !== expc || ix !== 8'(k) || sm !== exps) s_err++;
                if (n == 2) begin c0 = ch; sm0 = sm; end
                if (n == 2 + div) begin c1 = ch; sm1 = sm; end
            end else if (sm !== 16'sd0) begin
                s_err++;
            end
            if (dn === 1'b1) begin
                d_cnt++;
                if (d_at < 0) d_at = n;
            end
            if (en === 1'b1) begin
                if (ad !== 8'(rd_cnt)) a_err++;
                if (ad >= 8'd255) over = 1'b1;
                rd_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if ({busy4, valid4, chip4, done4, rom_en4} !== 5'b0) begin errors++; $display("FAIL reset_flags4: got %b expected 00000", {busy4, valid4, chip4, done4, rom_en4}); end
        checks++; if ({idx4, rom_addr4} !== 16'h0) begin errors++; $display("FAIL reset_idx_addr4: got %h expected 0000", {idx4, rom_addr4}); end
        checks++; if (samp4 !== 16'sd0) begin errors++; $display("FAIL reset_sample4: got %0d expected 0", samp4); end
        checks++; if ({busy2, valid2, chip2, done2, rom_en2, idx2, rom_addr2, samp2} !== 37'b0) begin errors++; $display("FAIL reset_all2: got %h expected 0", {busy2, valid2, chip2, done2, rom_en2, idx2, rom_addr2, samp2}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err; bit over; logic c0, c1; logic signed [15:0] sm0, sm1;
        do_start(1'b0, 4'd0);
        observe(1'b0, 0, 4, -1, s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err, over, c0, c1, sm0, sm1);
        checks++; if (c0 !== 1'b0) begin errors++; $display("FAIL basic_chip0: got %b expected 0", c0); end
        checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL basic_chip1: got %b expected 1", c1); end
        checks++; if (v_cnt !== 1020) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1020", v_cnt); end
        checks++; if (d_at !== 1022) begin errors++; $display("FAIL basic_done_time: got %0d expected 1022", d_at); end
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", d_cnt); end
        checks++; if (s_err !== 0) begin errors++; $display("FAIL basic_stream: got %0d bad cycles expected 0", s_err); end
        checks++; if (rd_cnt !== 255 || a_err !== 0) begin errors++; $display("FAIL basic_reads: got %0d reads %0d addr errs expected 255 and 0", rd_cnt, a_err); end
    endtask

    task automatic test_code1;
        int s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err; bit over; logic c0, c1; logic signed [15:0] sm0, sm1;
        do_start(1'b0, 4'd1);
        observe(1'b0, 1, 4, -1, s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err, over, c0, c1, sm0, sm1);
        checks++; if (c0 !== 1'b1 || c1 !== 1'b0) begin errors++; $display("FAIL code1_chips: got %b%b expected 10", c0, c1); end
        checks++; if (sm0 !== 16'sd8191) begin errors++; $display("FAIL code1_sample0: got %0d expected 8191", sm0); end
        checks++; if (sm1 !== -16'sd8191) begin errors++; $display("FAIL code1_sample1: got %0d expected -8191", sm1); end
        checks++; if (s_err !== 0) begin errors++; $display("FAIL code1_stream: got %0d bad cycles expected 0", s_err); end
    endtask

    task automatic test_div2;
        int s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err; bit over; logic c0, c1; logic signed [15:0] sm0, sm1;
        do_start(1'b1, 4'd3);
        observe(1'b1, 3, 2, -1, s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err, over, c0, c1, sm0, sm1);
        checks++; if (rd_cnt !== 255) begin errors++; $display("FAIL div2_read_count: got %0d expected 255", rd_cnt); end
        checks++; if (a_err !== 0) begin errors++; $display("FAIL div2_addr_order: got %0d errs expected 0", a_err); end
        checks++; if (over !== 1'b0) begin errors++; $display("FAIL div2_overread: got %b expected 0", over); end
        checks++; if (v_cnt !== 510) begin errors++; $display("FAIL div2_valid_cycles: got %0d expected 510", v_cnt); end
        checks++; if (d_at !== 512) begin errors++; $display("FAIL div2_done_time: got %0d expected 512", d_at); end
        checks++; if (s_err !== 0) begin errors++; $display("FAIL div2_stream: got %0d bad cycles expected 0", s_err); end
    endtask

    task automatic test_busy_start;
        int s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err; bit over; logic c0, c1; logic signed [15:0] sm0, sm1;
        do_start(1'b0, 4'd2);
        observe(1'b0, 2, 4, 402, s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err, over, c0, c1, sm0, sm1);
        checks++; if (s_err !== 0) begin errors++; $display("FAIL busy_start_stream: got %0d bad cycles expected 0", s_err); end
        checks++; if (d_at !== 1022 || d_cnt !== 1) begin errors++; $display("FAIL busy_start_done: got at %0d count %0d expected 1022 and 1", d_at, d_cnt); end
        checks++; if (rd_cnt !== 255) begin errors++; $display("FAIL busy_start_reads: got %0d expected 255", rd_cnt); end
    endtask

    task automatic test_start_abort_idle;
        int busy_seen = 0;
        @(negedge clk);
        start4 = 1'b1; abort4 = 1'b1; code4 = 4'd7;
        @(negedge clk);
        checks++; if (busy4 !== 1'b0 || rom_en4 !== 1'b0) begin errors++; $display("FAIL start_abort_idle: got busy %b rom_en %b expected 0 0", busy4, rom_en4); end
        start4 = 1'b0; abort4 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || valid4 !== 1'b0) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL start_abort_idle_after: got %0d active cycles expected 0", busy_seen); end
    endtask

    task automatic test_abort;
        int s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err; bit over; logic c0, c1; logic signed [15:0] sm0, sm1;
        int dn_seen = 0, bz_seen = 0;
        do_start(1'b0, 4'd5);
        @(negedge clk);
        start4 = 1'b0;
        repeat (70) @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        checks++; if ({busy4, valid4, done4, rom_en4} !== 4'b0) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {busy4, valid4, done4, rom_en4}); end
        checks++; if (samp4 !== 16'sd0) begin errors++; $display("FAIL abort_sample: got %0d expected 0", samp4); end
        repeat (1100) begin
            @(negedge clk);
            if (done4 === 1'b1) dn_seen++;
            if (busy4 === 1'b1) bz_seen++;
        end
        checks++; if (dn_seen !== 0 || bz_seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d done %0d busy cycles expected 0 0", dn_seen, bz_seen); end
        do_start(1'b0, 4'd6);
        observe(1'b0, 6, 4, -1, s_err, v_cnt, d_at, d_cnt, rd_cnt, a_err, over, c0, c1, sm0, sm1);
        checks++; if (s_err !== 0 || d_at !== 1022) begin errors++; $display("FAIL abort_restart: got %0d bad cycles done at %0d expected 0 and 1022", s_err, d_at); end
    endtask

    task automatic test_reset_mid_run;
        int dn_seen = 0, bz_seen = 0;
        do_start(1'b0, 4'd2);
        @(negedge clk);
        start4 = 1'b0;
        repeat (163) @(negedge clk);
        checks++; if (idx4 !== 8'd40) begin errors++; $display("FAIL midrun_position: got %0d expected 40", idx4); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy4, valid4, chip4, done4, rom_en4, idx4, rom_addr4} !== 21'b0) begin errors++; $display("FAIL midrun_reset_outputs: got %h expected 0", {busy4, valid4, chip4, done4, rom_en4, idx4, rom_addr4}); end
        checks++; if (samp4 !== 16'sd0) begin errors++; $display("FAIL midrun_reset_sample: got %0d expected 0", samp4); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) begin
            @(negedge clk);
            if (done4 === 1'b1) dn_seen++;
            if (busy4 === 1'b1) bz_seen++;
        end
        checks++; if (dn_seen !== 0 || bz_seen !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d done %0d busy cycles expected 0 0", dn_seen, bz_seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_code1();
        test_div2();
        test_busy_start();
        test_start_abort_idle();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
